// File: rtl/board_lock_clear_if.sv
// board_lock_clear_if: piece-lock inputs and playfield outputs of the board store
interface board_lock_clear_if;
    logic             lock;
    logic [4:0]       x0, x1, x2, x3;
    logic [5:0]       y0, y1, y2, y3;
    logic [19:0][9:0] board;
    logic             clearing;
    logic             done;
    logic [15:0]      lines_cleared;
    logic             game_over;
    modport master (
        output lock, x0, x1, x2, x3, y0, y1, y2, y3,
        input  board, clearing, done, lines_cleared, game_over
    );
    modport slave (
        input  lock, x0, x1, x2, x3, y0, y1, y2, y3,
        output board, clearing, done, lines_cleared, game_over
    );
endinterface

// File: rtl/board_lock_clear.sv
// board_lock_clear: 20x10 playfield that commits a landed piece then deletes full rows
module board_lock_clear (
    input logic          clk,
    input logic          reset,
    board_lock_clear_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state;
    logic [4:0]       r;
    logic [19:0][9:0] board, piece, up, collapsed;
    logic [15:0]      lines_cleared;
    logic             game_over, over;
    logic [3:0][4:0]  xs;
    logic [3:0][5:0]  ys;
    assign xs = {bus.x3, bus.x2, bus.x1, bus.x0};
    assign ys = {bus.y3, bus.y2, bus.y1, bus.y0};
    assign up = {10'h000, board[19:1]};
    // rasterise in-range cells into a board mask; non-sentinel cells above the top flag overflow
    always_comb begin
        piece = '0;
        over = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int y = 0; y < 20; y++)
                for (int x = 0; x < 10; x++)
                    if (xs[i] == 5'(x) && ys[i] == 6'(y)) piece[y][x] = 1'b1;
            if (xs[i] != 5'd31 && ys[i] != 6'd63 && ys[i] >= 6'd20) over = 1'b1;
        end
    end
    // rows below the pointer stay; the pointer row and everything above drop by one
    always_comb begin
        collapsed = '0;
        for (int i = 0; i < 20; i++) collapsed[i] = (5'(i) < r) ? board[i] : up[i];
    end
    // lock commit, bottom-up row scan with in-place re-check after each deletion
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            r <= '0;
            board <= '0;
            lines_cleared <= '0;
            game_over <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.lock) begin
                board <= board | piece;
                game_over <= game_over | over;
                r <= '0;
                state <= SCAN;
            end
        end else if (state == SCAN) begin
            if (board[r] == 10'h3FF) begin
                board <= collapsed;
                lines_cleared <= lines_cleared + 16'd1;
            end else if (r == 5'd19) begin
                state <= DONE;
            end else begin
                r <= r + 5'd1;
            end
        end else begin
            state <= IDLE;
        end
    end
    assign bus.board = board;
    assign bus.clearing = state == SCAN || state == DONE;
    assign bus.done = state == DONE;
    assign bus.lines_cleared = lines_cleared;
    assign bus.game_over = game_over;
endmodule

// File: tb/tb_board_lock_clear.sv
// tb_board_lock_clear: randomized and directed checks of board_lock_clear against a row-compaction model
module tb_board_lock_clear;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    board_lock_clear_if bus ();
    board_lock_clear dut (.clk(clk), .reset(reset), .bus(bus));
    typedef logic [3:0][4:0] xv_t;
    typedef logic [3:0][5:0] yv_t;
    typedef struct packed {
        logic [19:0][9:0] b0;
        logic             c0;
        logic [7:0]       lat;
        logic             cd;
        logic [19:0][9:0] bf;
        logic [15:0]      lc;
        logic             go;
        logic             ca;
        logic             da;
    } res_t;
    localparam xv_t XS = {4{5'd31}};
    localparam yv_t YS = {4{6'd63}};
    int n_cmp = 0;
    int n_fail = 0;
    logic [19:0][9:0] mb;
    logic mgo;
    logic [15:0] mlc;

    task automatic drive(input logic l, input xv_t xs, input yv_t ys);
        bus.lock = l;
        bus.x0 = xs[0]; bus.x1 = xs[1]; bus.x2 = xs[2]; bus.x3 = xs[3];
        bus.y0 = ys[0]; bus.y1 = ys[1]; bus.y2 = ys[2]; bus.y3 = ys[3];
    endtask

    task automatic do_reset;
        drive(1'b0, XS, YS);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mb = '0;
        mgo = 1'b0;
        mlc = '0;
    endtask

    task automatic run_lock(input xv_t xs, input yv_t ys, input int busy_at, input xv_t bxs, input yv_t bys, output res_t o);
        int lat;
        drive(1'b1, xs, ys);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, XS, YS);
        o.b0 = bus.board;
        o.c0 = bus.clearing;
        lat = 0;
        while (lat < 100) begin
            if (lat == busy_at) drive(1'b1, bxs, bys);
            @(posedge clk);
            lat++;
            @(negedge clk);
            drive(1'b0, XS, YS);
            if (bus.done) break;
        end
        o.lat = 8'(lat);
        o.cd = bus.clearing;
        @(posedge clk);
        @(negedge clk);
        o.bf = bus.board;
        o.lc = bus.lines_cleared;
        o.go = bus.game_over;
        o.ca = bus.clearing;
        o.da = bus.done;
    endtask

    task automatic model_lock(input xv_t xs, input yv_t ys, output res_t e);
        logic [19:0][9:0] nb;
        logic [4:0] j;
        int k;
        for (int i = 0; i < 4; i++) begin
            if (xs[i] <= 5'd9 && ys[i] <= 6'd19) mb[ys[i][4:0]][xs[i][3:0]] = 1'b1;
            if (xs[i] != 5'd31 && ys[i] != 6'd63 && ys[i] >= 6'd20) mgo = 1'b1;
        end
        e.b0 = mb;
        nb = '0;
        j = '0;
        k = 0;
        for (int r = 0; r < 20; r++) begin
            if (mb[r] == 10'h3FF) k++;
            else begin
                nb[j] = mb[r];
                j++;
            end
        end
        mb = nb;
        mlc = mlc + 16'(k);
        e.c0 = 1'b1;
        e.lat = 8'(20 + k);
        e.cd = 1'b1;
        e.bf = mb;
        e.lc = mlc;
        e.go = mgo;
        e.ca = 1'b0;
        e.da = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if (bus.board !== '0 || bus.clearing !== 1'b0 || bus.done !== 1'b0 || bus.lines_cleared !== 16'd0 || bus.game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got board=%h clr=%b done=%b lines=%0d go=%b want all zero", bus.board, bus.clearing, bus.done, bus.lines_cleared, bus.game_over);
        end
    endtask

    task automatic test_simple_lock;
        res_t o, e;
        do_reset();
        run_lock({5'd5, 5'd5, 5'd4, 5'd4}, {6'd1, 6'd0, 6'd1, 6'd0}, -1, XS, YS, o);
        model_lock({5'd5, 5'd5, 5'd4, 5'd4}, {6'd1, 6'd0, 6'd1, 6'd0}, e);
        n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL o_piece: got %h want %h", o, e); end
        n_cmp++;
        if (o.bf[0] !== 10'h030 || o.bf[1] !== 10'h030 || o.lat !== 8'd20) begin
            n_fail++;
            $display("FAIL o_piece_rows: got r0=%h r1=%h lat=%0d want 030 030 20", o.bf[0], o.bf[1], o.lat);
        end
    endtask

    task automatic test_single_clear;
        res_t o, e;
        do_reset();
        run_lock({5'd7, 5'd6, 5'd5, 5'd4}, {6'd0, 6'd0, 6'd0, 6'd0}, -1, XS, YS, o);
        model_lock({5'd7, 5'd6, 5'd5, 5'd4}, {6'd0, 6'd0, 6'd0, 6'd0}, e);
        run_lock({5'd31, 5'd0, 5'd9, 5'd8}, {6'd63, 6'd1, 6'd0, 6'd0}, -1, XS, YS, o);
        model_lock({5'd31, 5'd0, 5'd9, 5'd8}, {6'd63, 6'd1, 6'd0, 6'd0}, e);
        n_cmp++;
        if (o.bf[0] !== 10'h3F0 || o.bf[1] !== 10'h001) begin
            n_fail++;
            $display("FAIL clear_preload: got r0=%h r1=%h want 3f0 001", o.bf[0], o.bf[1]);
        end
        run_lock({5'd3, 5'd2, 5'd1, 5'd0}, {6'd0, 6'd0, 6'd0, 6'd0}, -1, XS, YS, o);
        model_lock({5'd3, 5'd2, 5'd1, 5'd0}, {6'd0, 6'd0, 6'd0, 6'd0}, e);
        n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL single_clear: got %h want %h", o, e); end
        n_cmp++;
        if (o.bf[0] !== 10'h001 || o.bf[1] !== 10'h000 || o.lc !== 16'd1 || o.lat !== 8'd21) begin
            n_fail++;
            $display("FAIL single_clear_rows: got r0=%h r1=%h lines=%0d lat=%0d want 001 000 1 21", o.bf[0], o.bf[1], o.lc, o.lat);
        end
    endtask

    task automatic test_non_adjacent;
        res_t o, e;
        xv_t px [5];
        yv_t py [5];
        px[0] = {5'd3, 5'd2, 5'd1, 5'd0};  py[0] = {6'd0, 6'd0, 6'd0, 6'd0};
        px[1] = {5'd7, 5'd6, 5'd5, 5'd4};  py[1] = {6'd0, 6'd0, 6'd0, 6'd0};
        px[2] = {5'd2, 5'd1, 5'd0, 5'd8};  py[2] = {6'd2, 6'd2, 6'd2, 6'd0};
        px[3] = {5'd6, 5'd5, 5'd4, 5'd3};  py[3] = {6'd2, 6'd2, 6'd2, 6'd2};
        px[4] = {5'd31, 5'd9, 5'd8, 5'd7}; py[4] = {6'd63, 6'd1, 6'd2, 6'd2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_lock(px[i], py[i], -1, XS, YS, o);
            model_lock(px[i], py[i], e);
        end
        run_lock({4{5'd9}}, {6'd3, 6'd2, 6'd1, 6'd0}, -1, XS, YS, o);
        model_lock({4{5'd9}}, {6'd3, 6'd2, 6'd1, 6'd0}, e);
        n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL non_adjacent: got %h want %h", o, e); end
        n_cmp++;
        if (o.bf[0] !== 10'h200 || o.bf[1] !== 10'h200 || o.bf[19:2] !== '0 || o.lc !== 16'd2 || o.lat !== 8'd22) begin
            n_fail++;
            $display("FAIL non_adjacent_rows: got r0=%h r1=%h lines=%0d lat=%0d want 200 200 2 22", o.bf[0], o.bf[1], o.lc, o.lat);
        end
    endtask

    task automatic test_overflow_sentinel;
        res_t o, e;
        do_reset();
        run_lock({5'd3, 5'd2, 5'd1, 5'd0}, {6'd20, 6'd19, 6'd19, 6'd19}, -1, XS, YS, o);
        model_lock({5'd3, 5'd2, 5'd1, 5'd0}, {6'd20, 6'd19, 6'd19, 6'd19}, e);
        n_cmp++;
        if (o !== e || o.go !== 1'b1 || o.bf[19] !== 10'h007) begin
            n_fail++;
            $display("FAIL overflow: got go=%b r19=%h want go=1 r19=007", o.go, o.bf[19]);
        end
        run_lock({5'd8, 5'd7, 5'd6, 5'd5}, {6'd0, 6'd0, 6'd0, 6'd0}, -1, XS, YS, o);
        model_lock({5'd8, 5'd7, 5'd6, 5'd5}, {6'd0, 6'd0, 6'd0, 6'd0}, e);
        n_cmp++;
        if (o !== e || o.go !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %h want %h", o, e); end
        run_lock(XS, YS, -1, XS, YS, o);
        model_lock(XS, YS, e);
        n_cmp++;
        if (o !== e || o.bf !== o.b0 || o.lat !== 8'd20) begin n_fail++; $display("FAIL all_sentinel: got %h want %h", o, e); end
    endtask

    task automatic test_lock_while_busy;
        res_t o, e;
        do_reset();
        run_lock({5'd5, 5'd5, 5'd4, 5'd4}, {6'd1, 6'd0, 6'd1, 6'd0}, 3, {5'd3, 5'd2, 5'd1, 5'd0}, {4{6'd5}}, o);
        model_lock({5'd5, 5'd5, 5'd4, 5'd4}, {6'd1, 6'd0, 6'd1, 6'd0}, e);
        n_cmp++;
        if (o !== e || o.bf[5] !== 10'h000) begin n_fail++; $display("FAIL lock_while_busy: got %h want %h", o, e); end
    endtask

    task automatic test_random;
        res_t o, e;
        xv_t xs, bxs;
        yv_t ys, bys;
        int busy;
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] = 5'($urandom_range(0, 9));
                ys[i] = 6'($urandom_range(0, 3));
                bxs[i] = 5'($urandom_range(0, 9));
                bys[i] = 6'($urandom_range(0, 19));
                case ($urandom_range(0, 19))
                    0: xs[i] = 5'd31;
                    1: ys[i] = 6'd63;
                    2: ys[i] = 6'($urandom_range(20, 62));
                    default: ;
                endcase
            end
            busy = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 19)) : -1;
            run_lock(xs, ys, busy, bxs, bys, o);
            model_lock(xs, ys, e);
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL random_%0d: got %h want %h", n, o, e); end
        end
    endtask

    task automatic test_reset_mid_scan;
        res_t o, e;
        drive(1'b1, {5'd3, 5'd2, 5'd1, 5'd0}, {4{6'd21}});
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, XS, YS);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (bus.board !== '0 || bus.clearing !== 1'b0 || bus.done !== 1'b0 || bus.lines_cleared !== 16'd0 || bus.game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_scan: got board=%h clr=%b done=%b lines=%0d go=%b want all zero", bus.board, bus.clearing, bus.done, bus.lines_cleared, bus.game_over);
        end
        mb = '0;
        mgo = 1'b0;
        mlc = '0;
        run_lock({5'd5, 5'd5, 5'd4, 5'd4}, {6'd1, 6'd0, 6'd1, 6'd0}, -1, XS, YS, o);
        model_lock({5'd5, 5'd5, 5'd4, 5'd4}, {6'd1, 6'd0, 6'd1, 6'd0}, e);
        n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL lock_after_reset: got %h want %h", o, e); end
    endtask

    initial begin
        drive(1'b0, XS, YS);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_simple_lock();
        test_single_clear();
        test_non_adjacent();
        test_overflow_sentinel();
        test_lock_while_busy();
        do_reset();
        test_random();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
